// File: rtl/stack_drop_judge.sv
// ---------------------------------------------------------------------------
// stack_drop_judge
//   Upstream stage of the block-stacker level tracker. Sweeps the active
//   row's segment back and forth across the board, latches it on a drop,
//   and judges it against the row below (hit -> level_up, miss -> game_over,
//   last level -> win). Both row masks are exported for drawing.
//
// Ports:
//   clk         system clock
//   resetn      synchronous, active-low reset
//   step_tick   one-cycle move strobe from the rate divider
//   drop_btn    synchronised, level-sensitive drop button
//   row_mask    cells occupied by the moving segment (bit COLS-1 leftmost)
//   below_mask  cells occupied by the last placed row
//   level       count of successful drops so far
//   level_up    one-cycle pulse on a successful drop
//   game_over   one-cycle pulse on a miss
//   win         one-cycle pulse on completing level LEVELS
//   busy        high in every state except MOVE
//
// Build option:
//   SPEED_RAMP_EN  when defined, step_tick is divided by
//                  max(1, BASE_DIV - level) so the sweep speeds up per level.
// ---------------------------------------------------------------------------
module stack_drop_judge #(
  parameter int COLS       = 16,
  parameter int INIT_WIDTH = 3,
  parameter int LEVELS     = 15,
  parameter int LW         = 4,
  parameter int BASE_DIV   = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            step_tick,
  input  logic            drop_btn,
  output logic [COLS-1:0] row_mask,
  output logic [COLS-1:0] below_mask,
  output logic [LW-1:0]   level,
  output logic            level_up,
  output logic            game_over,
  output logic            win,
  output logic            busy
);

  typedef enum logic [2:0] {
    S_MOVE, S_EVAL, S_ADVANCE, S_LOSE, S_WAIT_REL
  } state_t;

  localparam logic [COLS-1:0] INIT_ROW = {{(COLS-INIT_WIDTH){1'b0}}, {INIT_WIDTH{1'b1}}};
  localparam logic            DIR_LEFT = 1'b1;

  state_t          state_reg, state_next;
  logic [COLS-1:0] row_mask_reg, row_mask_next;
  logic [COLS-1:0] below_mask_reg, below_mask_next;
  logic [LW-1:0]   level_reg, level_next;
  logic            dir_reg, dir_next;
  logic            drop_q_reg;
  logic            restart_reg, restart_next;
  logic            level_up_reg, level_up_next;
  logic            game_over_reg, game_over_next;
  logic            win_reg, win_next;

  logic            drop_edge;
  logic            move_ev;
  logic [COLS-1:0] overlap;

  assign drop_edge = drop_btn & ~drop_q_reg;
  assign overlap   = row_mask_reg & below_mask_reg;

`ifdef SPEED_RAMP_EN
  localparam int DW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam int NW = DW + 1;

  logic [DW-1:0] div_cnt_reg, div_cnt_next;
  logic [NW-1:0] div_n;

  // Divisor shrinks by one per level, floored at 1 (every tick moves).
  always_comb begin
    if (int'(level_reg) < BASE_DIV - 1)
      div_n = NW'(BASE_DIV - int'(level_reg));
    else
      div_n = NW'(1);
  end

  assign move_ev = step_tick & ({1'b0, div_cnt_reg} >= div_n - 1'b1);
`else
  assign move_ev = step_tick;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= S_MOVE;
      row_mask_reg   <= INIT_ROW;
      below_mask_reg <= '1;
      level_reg      <= '0;
      dir_reg        <= DIR_LEFT;
      drop_q_reg     <= 1'b1;   // a button held through reset must be released first
      restart_reg    <= 1'b0;
      level_up_reg   <= 1'b0;
      game_over_reg  <= 1'b0;
      win_reg        <= 1'b0;
`ifdef SPEED_RAMP_EN
      div_cnt_reg    <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      row_mask_reg   <= row_mask_next;
      below_mask_reg <= below_mask_next;
      level_reg      <= level_next;
      dir_reg        <= dir_next;
      drop_q_reg     <= drop_btn;
      restart_reg    <= restart_next;
      level_up_reg   <= level_up_next;
      game_over_reg  <= game_over_next;
      win_reg        <= win_next;
`ifdef SPEED_RAMP_EN
      div_cnt_reg    <= div_cnt_next;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_MOVE:     if (drop_edge) state_next = S_EVAL;
      S_EVAL:     state_next = (overlap == '0) ? S_LOSE : S_ADVANCE;
      S_ADVANCE:  state_next = S_WAIT_REL;
      S_LOSE:     state_next = S_WAIT_REL;
      S_WAIT_REL: if (!drop_btn) state_next = S_MOVE;
      default:    state_next = S_MOVE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    row_mask_next   = row_mask_reg;
    below_mask_next = below_mask_reg;
    level_next      = level_reg;
    dir_next        = dir_reg;
    restart_next    = restart_reg;
    level_up_next   = 1'b0;
    game_over_next  = 1'b0;
    win_next        = 1'b0;
`ifdef SPEED_RAMP_EN
    // Held at zero outside MOVE so every entry to MOVE starts a fresh count.
    div_cnt_next    = '0;
`endif
    case (state_reg)
      S_MOVE: begin
`ifdef SPEED_RAMP_EN
        div_cnt_next = div_cnt_reg;
        if (step_tick && !drop_edge)
          div_cnt_next = move_ev ? '0 : div_cnt_reg + 1'b1;
`endif
        // A drop edge wins over a same-cycle move; that move is discarded.
        if (move_ev && !drop_edge) begin
          if (dir_reg == DIR_LEFT) begin
            if (row_mask_reg[COLS-1]) begin
              dir_next      = ~DIR_LEFT;
              row_mask_next = row_mask_reg >> 1;
            end else begin
              row_mask_next = row_mask_reg << 1;
            end
          end else begin
            if (row_mask_reg[0]) begin
              dir_next      = DIR_LEFT;
              row_mask_next = row_mask_reg << 1;
            end else begin
              row_mask_next = row_mask_reg >> 1;
            end
          end
        end
      end
      S_EVAL: begin
        if (overlap != '0) begin
          row_mask_next   = overlap;
          below_mask_next = overlap;
          level_next      = level_reg + LW'(1);
        end
      end
      S_ADVANCE: begin
        level_up_next = 1'b1;
        if (level_reg == LW'(LEVELS)) begin
          win_next     = 1'b1;
          restart_next = 1'b1;
        end
      end
      S_LOSE: begin
        game_over_next = 1'b1;
        restart_next   = 1'b1;
      end
      S_WAIT_REL: begin
        if (!drop_btn && restart_reg) begin
          row_mask_next   = INIT_ROW;
          below_mask_next = '1;
          level_next      = '0;
          dir_next        = DIR_LEFT;
          restart_next    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign row_mask   = row_mask_reg;
  assign below_mask = below_mask_reg;
  assign level      = level_reg;
  assign level_up   = level_up_reg;
  assign game_over  = game_over_reg;
  assign win        = win_reg;
  assign busy       = (state_reg != S_MOVE);

endmodule

// File: tb/tb_stack_drop_judge.sv
// ---------------------------------------------------------------------------
// tb_stack_drop_judge
//   Directed bench for stack_drop_judge. Three instances share the stimulus:
//     dut_a  LEVELS=15, BASE_DIV=1  (every tick moves in either build)
//     dut_b  LEVELS=3               (win sequence)
//     dut_c  LEVELS=15, BASE_DIV=4  (speed ramp)
//   Each vector is one clock: inputs driven, edge, outputs sampled 1ns later.
// ---------------------------------------------------------------------------
module tb_stack_drop_judge;

  logic clk = 1'b0;
  logic resetn, step_tick, drop_btn;

  always #5 clk = ~clk;

  logic [15:0] row_a, below_a, row_b, below_b, row_c, below_c;
  logic [3:0]  level_a, level_b, level_c;
  logic        lu_a, go_a, win_a, busy_a;
  logic        lu_b, go_b, win_b, busy_b;
  logic        lu_c, go_c, win_c, busy_c;

  stack_drop_judge #(.COLS(16), .INIT_WIDTH(3), .LEVELS(15), .LW(4), .BASE_DIV(1)) dut_a (
    .clk(clk), .resetn(resetn), .step_tick(step_tick), .drop_btn(drop_btn),
    .row_mask(row_a), .below_mask(below_a), .level(level_a),
    .level_up(lu_a), .game_over(go_a), .win(win_a), .busy(busy_a));

  stack_drop_judge #(.COLS(16), .INIT_WIDTH(3), .LEVELS(3), .LW(4), .BASE_DIV(1)) dut_b (
    .clk(clk), .resetn(resetn), .step_tick(step_tick), .drop_btn(drop_btn),
    .row_mask(row_b), .below_mask(below_b), .level(level_b),
    .level_up(lu_b), .game_over(go_b), .win(win_b), .busy(busy_b));

  stack_drop_judge #(.COLS(16), .INIT_WIDTH(3), .LEVELS(15), .LW(4), .BASE_DIV(4)) dut_c (
    .clk(clk), .resetn(resetn), .step_tick(step_tick), .drop_btn(drop_btn),
    .row_mask(row_c), .below_mask(below_c), .level(level_c),
    .level_up(lu_c), .game_over(go_c), .win(win_c), .busy(busy_c));

  typedef struct {
    bit          rst;
    bit          tick;
    bit          drop;
    logic [15:0] row;
    logic [15:0] below;
    logic [3:0]  lvl;
    bit          lu;
    bit          go;
    bit          bsy;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  function automatic void add(bit r, bit t, bit d, logic [15:0] row, logic [15:0] below,
                              logic [3:0] lvl, bit lu, bit go, bit bsy);
    vec_t v;
    v.rst = r; v.tick = t; v.drop = d; v.row = row; v.below = below;
    v.lvl = lvl; v.lu = lu; v.go = go; v.bsy = bsy;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
  endtask

  // One clock: drive inputs, take the edge, settle.
  task automatic cyc(input bit r, input bit t, input bit d);
    resetn    = ~r;
    step_tick = t;
    drop_btn  = d;
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    step_tick = 1'b0;
  endtask

  // Full press/hold/release: EVAL, ADVANCE/LOSE, WAIT_REL (pulse visible), release.
  task automatic press(output bit lu_seen, output bit win_seen);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    lu_seen  = lu_b;
    win_seen = win_b;
    cyc(0, 0, 0);
  endtask

  initial begin
    bit lu_s, win_s;
    logic [15:0] sweep [15];

    resetn = 1'b0; step_tick = 1'b0; drop_btn = 1'b0;

    // ---------------- vector table (dut_a) ----------------
    sweep = '{16'h000E, 16'h001C, 16'h0038, 16'h0070, 16'h00E0, 16'h01C0, 16'h0380,
              16'h0700, 16'h0E00, 16'h1C00, 16'h3800, 16'h7000, 16'hE000,
              16'h7000, 16'h3800};
    // r t d  row      below    lvl lu go busy
    add(1,0,0, 16'h0007, 16'hFFFF, 0, 0, 0, 0);          // reset state
    add(0,0,0, 16'h0007, 16'hFFFF, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++)                         // sweep + bounce
      add(0,1,0, sweep[i], 16'hFFFF, 0, 0, 0, 0);
    add(1,0,0, 16'h0007, 16'hFFFF, 0, 0, 0, 0);
    add(0,0,0, 16'h0007, 16'hFFFF, 0, 0, 0, 0);
    add(0,0,1, 16'h0007, 16'hFFFF, 0, 0, 0, 1);          // EVAL
    add(0,0,1, 16'h0007, 16'h0007, 1, 0, 0, 1);          // ADVANCE
    add(0,0,1, 16'h0007, 16'h0007, 1, 1, 0, 1);          // level_up pulse
    add(0,0,0, 16'h0007, 16'h0007, 1, 0, 0, 0);          // released -> MOVE
    add(0,1,0, 16'h000E, 16'h0007, 1, 0, 0, 0);
    add(0,1,0, 16'h001C, 16'h0007, 1, 0, 0, 0);
    add(0,0,1, 16'h001C, 16'h0007, 1, 0, 0, 1);          // EVAL
    add(0,0,0, 16'h0004, 16'h0004, 2, 0, 0, 1);          // shrink to overlap
    add(0,0,0, 16'h0004, 16'h0004, 2, 1, 0, 1);
    add(0,0,0, 16'h0004, 16'h0004, 2, 0, 0, 0);
    add(0,1,0, 16'h0008, 16'h0004, 2, 0, 0, 0);
    add(0,1,0, 16'h0010, 16'h0004, 2, 0, 0, 0);
    add(0,1,0, 16'h0020, 16'h0004, 2, 0, 0, 0);
    add(0,1,0, 16'h0040, 16'h0004, 2, 0, 0, 0);
    add(0,1,0, 16'h0080, 16'h0004, 2, 0, 0, 0);
    add(0,1,0, 16'h0100, 16'h0004, 2, 0, 0, 0);
    add(0,0,1, 16'h0100, 16'h0004, 2, 0, 0, 1);          // EVAL (miss)
    add(0,0,1, 16'h0100, 16'h0004, 2, 0, 0, 1);          // LOSE
    add(0,0,1, 16'h0100, 16'h0004, 2, 0, 1, 1);          // game_over pulse
    for (int i = 0; i < 5; i++)                          // held, ticks ignored
      add(0,1,1, 16'h0100, 16'h0004, 2, 0, 0, 1);
    add(0,0,0, 16'h0007, 16'hFFFF, 0, 0, 0, 0);          // restart values
    add(0,1,0, 16'h000E, 16'hFFFF, 0, 0, 0, 0);
    add(0,1,0, 16'h001C, 16'hFFFF, 0, 0, 0, 0);
    add(0,1,0, 16'h0038, 16'hFFFF, 0, 0, 0, 0);
    add(0,1,1, 16'h0038, 16'hFFFF, 0, 0, 0, 1);          // tick + drop: no shift
    add(0,0,1, 16'h0038, 16'h0038, 1, 0, 0, 1);
    add(0,0,0, 16'h0038, 16'h0038, 1, 1, 0, 1);
    add(0,0,0, 16'h0038, 16'h0038, 1, 0, 0, 0);
    add(1,0,1, 16'h0007, 16'hFFFF, 0, 0, 0, 0);          // held through reset
    add(0,0,1, 16'h0007, 16'hFFFF, 0, 0, 0, 0);
    add(0,0,1, 16'h0007, 16'hFFFF, 0, 0, 0, 0);
    add(0,0,1, 16'h0007, 16'hFFFF, 0, 0, 0, 0);
    add(0,0,0, 16'h0007, 16'hFFFF, 0, 0, 0, 0);
    add(0,0,1, 16'h0007, 16'hFFFF, 0, 0, 0, 1);          // re-press -> EVAL
    add(1,0,1, 16'h0007, 16'hFFFF, 0, 0, 0, 0);          // reset during EVAL
    add(0,0,0, 16'h0007, 16'hFFFF, 0, 0, 0, 0);          // no late pulses

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].tick, vecs[i].drop);
      $display("vec %0d r=%0b t=%0b d=%0b row=%04h below=%04h lvl=%0d lu=%0b go=%0b busy=%0b",
               i, vecs[i].rst, vecs[i].tick, vecs[i].drop, row_a, below_a, level_a, lu_a, go_a, busy_a);
      chk("row_mask",   i, 32'(row_a),   32'(vecs[i].row));
      chk("below_mask", i, 32'(below_a), 32'(vecs[i].below));
      chk("level",      i, 32'(level_a), 32'(vecs[i].lvl));
      chk("level_up",   i, 32'(lu_a),    32'(vecs[i].lu));
      chk("game_over",  i, 32'(go_a),    32'(vecs[i].go));
      chk("busy",       i, 32'(busy_a),  32'(vecs[i].bsy));
      chk("win_a",      i, 32'(win_a),   32'd0);
    end

    // ---------------- win sequence (dut_b, LEVELS=3) ----------------
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    press(lu_s, win_s);
    $display("win press 1 lu=%0b win=%0b level=%0d", lu_s, win_s, level_b);
    chk("win_p1_lu", 1, 32'(lu_s), 32'd1);
    chk("win_p1_win", 1, 32'(win_s), 32'd0);
    press(lu_s, win_s);
    $display("win press 2 lu=%0b win=%0b level=%0d", lu_s, win_s, level_b);
    chk("win_p2_win", 2, 32'(win_s), 32'd0);
    chk("win_p2_level", 2, 32'(level_b), 32'd2);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    $display("win press 3 lu=%0b win=%0b level=%0d", lu_b, win_b, level_b);
    chk("win_p3_lu", 3, 32'(lu_b), 32'd1);
    chk("win_p3_win", 3, 32'(win_b), 32'd1);
    chk("win_p3_level", 3, 32'(level_b), 32'd3);
    cyc(0, 0, 0);
    $display("win release level=%0d row=%04h win=%0b", level_b, row_b, win_b);
    chk("win_rel_level", 4, 32'(level_b), 32'd0);
    chk("win_rel_row", 4, 32'(row_b), 32'h0007);
    chk("win_rel_below", 4, 32'(below_b), 32'hFFFF);
    chk("win_rel_pulse", 4, 32'(win_b), 32'd0);

    // ---------------- speed ramp (dut_c, BASE_DIV=4) ----------------
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    $display("ramp 3 ticks row=%04h", row_c);
`ifdef SPEED_RAMP_EN
    chk("ramp_3ticks", 0, 32'(row_c), 32'h0007);
`else
    chk("ramp_3ticks", 0, 32'(row_c), 32'h0038);
`endif
    cyc(0, 1, 0);
    $display("ramp 4 ticks row=%04h", row_c);
`ifdef SPEED_RAMP_EN
    chk("ramp_4ticks", 0, 32'(row_c), 32'h000E);
`else
    chk("ramp_4ticks", 0, 32'(row_c), 32'h0070);
`endif
    for (int i = 0; i < 3; i++) press(lu_s, win_s);
    $display("ramp after 3 drops level=%0d row=%04h", level_c, row_c);
    chk("ramp_level", 1, 32'(level_c), 32'd3);
    cyc(0, 1, 0);
    $display("ramp one tick row=%04h", row_c);
`ifdef SPEED_RAMP_EN
    chk("ramp_fast", 1, 32'(row_c), 32'h001C);
`else
    chk("ramp_fast", 1, 32'(row_c), 32'h00E0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stack_drop_judge.md
Name: stack_drop_judge

Overview:
- Upstream stage of the vertical level tracker in the block-stacker game.
- Sweeps the active row's block segment left and right across the board and latches it when the player drops.
- Compares the dropped segment against the stacked row below: emits a one-cycle level_up pulse on a hit, game_over on a miss, and win after the final level.
- Also exports both row masks for the VGA drawing path.

Parameters:
- COLS, 16, board width in cells; one mask bit per cell, bit COLS-1 is leftmost.
- INIT_WIDTH, 3, segment width at game start; must satisfy 1 <= INIT_WIDTH < COLS.
- LEVELS, 15, number of successful drops that wins the game.
- LW, 4, width of the level output; must satisfy 2^LW > LEVELS.
- BASE_DIV, 8, base step_tick divisor; used only with SPEED_RAMP_EN.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- step_tick  in  1  one-cycle move strobe from the rate divider.
- drop_btn  in  1  drop button, already synchronised, level-sensitive.
- row_mask  out  COLS  cells occupied by the moving segment.
- below_mask  out  COLS  cells occupied by the last placed row.
- level  out  LW  count of successful drops so far.
- level_up  out  1  one-cycle pulse on a successful drop.
- game_over  out  1  one-cycle pulse on a miss.
- win  out  1  one-cycle pulse on completing level LEVELS.
- busy  out  1  high in every state except MOVE.

Behaviour:
- Reset (resetn=0 at a clk edge) returns everything to the initial state, from any state, including mid-evaluation:
  - row_mask = INIT_WIDTH ones at bits [INIT_WIDTH-1:0]; below_mask = all ones.
  - level = 0; dir = left (toward MSB); state = MOVE.
  - level_up, game_over, win = 0; drop_q = 1, so a button held through reset must be released before it counts.
- Drop edge: drop_edge = drop_btn & ~drop_q, where drop_q is drop_btn registered every cycle.
- States: MOVE, EVAL, ADVANCE, LOSE, WAIT_REL. All outputs are registered or Moore.
- MOVE:
  - drop_edge -> EVAL. drop_edge has priority over a same-cycle step_tick, and that tick is discarded.
  - Otherwise, on a move event, shift row_mask one cell in direction dir.
  - Bounce, dir = left: if row_mask[COLS-1]=1, set dir = right and shift right in the same event.
  - Bounce, dir = right: if row_mask[0]=1, set dir = left and shift left in the same event.
  - The segment never leaves the board and is never clipped while moving.
- EVAL (exactly 1 cycle): ov = row_mask & below_mask.
  - ov == 0 -> LOSE.
  - ov != 0 -> below_mask <= ov, row_mask <= ov (segment shrinks to the overlap), level <= level+1, -> ADVANCE.
  - dir is kept unchanged.
- ADVANCE (1 cycle): level_up = 1. If level == LEVELS, also win = 1 and set restart flag. -> WAIT_REL.
- LOSE (1 cycle): game_over = 1; set restart flag. -> WAIT_REL.
- WAIT_REL:
  - Stay while drop_btn = 1.
  - When drop_btn = 0: if restart flag is set, reload the reset values for row_mask, below_mask, level, dir, and clear the flag. -> MOVE.
- Latency: drop_btn first sampled high at edge N -> EVAL after N+1 -> level_up/game_over high for the single cycle after N+2.
- step_tick outside MOVE is ignored and never queued.
- Holding the button produces exactly one evaluation; a re-press is required.
- Width rule: mask operations are strictly COLS-bit; no carry or overflow is possible.
- level saturates by construction: it restarts before exceeding LEVELS.

Optional Feature:
- Macro: SPEED_RAMP_EN.
- Defined:
  - An internal counter divides step_tick; a move event occurs every N step_ticks, N = max(1, BASE_DIV - level).
  - The counter clears on reset, on entry to MOVE, and on each move event.
- Undefined: every step_tick in MOVE is a move event, and there is no divider logic.

Test Plan:
- Reset, COLS=16, INIT_WIDTH=3 -> row_mask=0x0007, below_mask=0xFFFF, level=0, all pulses 0, busy=0. Then 13 step_ticks -> 0xE000; 14th tick -> 0x7000 (bounce); 15th -> 0x3800.
- From reset, drop at 0x0007 -> level_up one cycle, exactly 2 edges after drop_btn is sampled high; below_mask=0x0007, level=1. Release; 2 ticks -> 0x001C; drop -> row_mask=below_mask=0x0004, level=2.
- Width-1 row at 0x0004, move to 0x0100, drop -> game_over one cycle, level_up stays 0. Hold button 5 cycles: stays in WAIT_REL, busy=1. Release -> reset values restored.
- LEVELS=3, three aligned drops -> third drop gives level_up and win in the same cycle. After release, level=0, row_mask=0x0007.
- Same-cycle step_tick and drop edge at 0x0038 -> no shift, evaluates 0x0038. Button held through reset then kept high -> no evaluation until released and re-pressed. resetn low during EVAL -> next cycle shows reset values, no pulses.
- SPEED_RAMP_EN, BASE_DIV=4: level 0 -> one shift per 4 step_ticks; after 3 successful drops -> one shift per step_tick.
